// File: rtl/project_soc_usb_rst_seq.sv
// Avalon-MM reset sequencer for the external USB controller: timed active-low
// reset pulse, settle interval, then done status / level interrupt.
module project_soc_usb_rst_seq #(
  parameter logic [15:0] PULSE_DEFAULT  = 16'd50000,
  parameter logic [15:0] SETTLE_DEFAULT = 16'd50000,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] PULSE_INIT  = (PULSE_DEFAULT  == 16'd0) ? 16'd1 : PULSE_DEFAULT;
  localparam logic [15:0] SETTLE_INIT = (SETTLE_DEFAULT == 16'd0) ? 16'd1 : SETTLE_DEFAULT;
  localparam state_t      STATE_INIT  = AUTO_START ? ST_ASSERT : ST_IDLE;
  localparam logic [15:0] COUNT_INIT  = AUTO_START ? PULSE_INIT : 16'd0;

  state_t      state;
  logic [15:0] counter;
  logic [15:0] settle_len;
  logic [15:0] pulse_reg;
  logic [15:0] settle_reg;
  logic        irq_en;
  logic        done;
  logic [7:0]  seq_count;

  logic wr, wr_ctrl, wr_pulse, wr_settle, wr_stat, start;
  logic unused_wdata;

  assign wr        = chipselect && !write_n;
  assign wr_ctrl   = wr && (address == 2'd0);
  assign wr_pulse  = wr && (address == 2'd1);
  assign wr_settle = wr && (address == 2'd2);
  assign wr_stat   = wr && (address == 2'd3);
  assign start     = wr_ctrl && writedata[0];

  assign unused_wdata = ^writedata[31:16];

  assign busy = (state != ST_IDLE);
  assign irq  = done & irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STATE_INIT;
      counter    <= COUNT_INIT;
      settle_len <= SETTLE_INIT;
      pulse_reg  <= PULSE_DEFAULT;
      settle_reg <= SETTLE_DEFAULT;
      usb_rst_n  <= 1'b0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      seq_count  <= '0;
    end else begin
      if (wr_ctrl)   irq_en     <= writedata[1];
      if (wr_pulse)  pulse_reg  <= writedata[15:0];
      if (wr_settle) settle_reg <= writedata[15:0];
      // Clear first so a completion in the same cycle overrides it.
      if (wr_stat)   done       <= 1'b0;

      case (state)
        ST_IDLE: begin
          usb_rst_n <= 1'b1;
          if (start) begin
            state      <= ST_ASSERT;
            usb_rst_n  <= 1'b0;
            counter    <= (pulse_reg  == 16'd0) ? 16'd1 : pulse_reg;
            settle_len <= (settle_reg == 16'd0) ? 16'd1 : settle_reg;
            done       <= 1'b0;
          end
        end
        ST_ASSERT: begin
          usb_rst_n <= 1'b0;
          if (counter == 16'd1) begin
            state     <= ST_SETTLE;
            usb_rst_n <= 1'b1;
            counter   <= settle_len;
          end else begin
            counter <= counter - 16'd1;
          end
        end
        ST_SETTLE: begin
          usb_rst_n <= 1'b1;
          if (counter == 16'd1) begin
            state     <= ST_IDLE;
            done      <= 1'b1;
            seq_count <= seq_count + 8'd1;
          end else begin
            counter <= counter - 16'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          usb_rst_n <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {27'd0, state, done, irq_en, busy};
      2'd1:    readdata = {16'd0, pulse_reg};
      2'd2:    readdata = {16'd0, settle_reg};
      default: readdata = {24'd0, seq_count};
    endcase
  end

endmodule

// File: tb/tb_project_soc_usb_rst_seq.sv
// Directed bench: dut_a (AUTO_START, 4/3 defaults) and dut_b (software START).
module tb_project_soc_usb_rst_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  address_a = 2'd0;
  logic [31:0] readdata_a;
  logic        usb_rst_n_a, busy_a, irq_a;

  logic [1:0]  address_b = 2'd0;
  logic        chipselect_b = 1'b0;
  logic        write_n_b = 1'b1;
  logic [31:0] writedata_b = '0;
  logic [31:0] readdata_b;
  logic        usb_rst_n_b, busy_b, irq_b;

  int checks = 0;
  int failures = 0;

  project_soc_usb_rst_seq #(
    .PULSE_DEFAULT (16'd4),
    .SETTLE_DEFAULT(16'd3),
    .AUTO_START    (1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address_a), .chipselect(1'b0),
    .write_n(1'b1), .writedata(32'd0), .readdata(readdata_a),
    .usb_rst_n(usb_rst_n_a), .busy(busy_a), .irq(irq_a)
  );

  project_soc_usb_rst_seq #(
    .PULSE_DEFAULT (16'd50000),
    .SETTLE_DEFAULT(16'd50000),
    .AUTO_START    (1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address_b), .chipselect(chipselect_b),
    .write_n(write_n_b), .writedata(writedata_b), .readdata(readdata_b),
    .usb_rst_n(usb_rst_n_b), .busy(busy_b), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address_b = a; writedata_b = d; chipselect_b = 1'b1; write_n_b = 1'b0;
    @(negedge clk);
    chipselect_b = 1'b0; write_n_b = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address_b = a;
    #1;
    d = readdata_b;
  endtask

  // Counts negedge samples from now until busy drops; returns at first idle sample.
  task automatic measure(output int low_c, output int busy_c, output int irq_c);
    int guard = 0;
    low_c = 0; busy_c = 0; irq_c = 0;
    while (busy_b && guard < 5000) begin
      if (!usb_rst_n_b) low_c++;
      if (irq_b) irq_c++;
      busy_c++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 5000) chk("busy_timeout", guard, 0);
  endtask

  initial begin
    int lo, bu, iq, g;
    logic [31:0] rd;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("a_rst_usb_n", usb_rst_n_a, 0);
    chk("a_rst_busy", busy_a, 1);
    chk("b_rst_usb_n", usb_rst_n_b, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_irq", irq_b, 0);
    bus_read(2'd1, rd); chk("b_rst_pulse", rd, 50000);

    // AUTO_START sequence on dut_a
    reset_n = 1'b1;
    lo = 0; bu = 0; g = 0;
    while (busy_a && g < 100) begin
      if (!usb_rst_n_a) lo++;
      bu++; g++;
      @(negedge clk);
    end
    chk("a_auto_low", lo, 4);
    chk("a_auto_busy", bu, 7);
    chk("a_auto_usb_high", usb_rst_n_a, 1);
    address_a = 2'd0; #1; chk("a_ctrl", readdata_a, 32'h4);
    address_a = 2'd3; #1; chk("a_stat", readdata_a, 32'h1);
    chk("a_irq", irq_a, 0);
    chk("b_idle_usb_n", usb_rst_n_b, 1);
    chk("b_idle_busy", busy_b, 0);

    // Basic 10/5 sequence with irq
    bus_write(2'd1, 32'd10);
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'h3);
    chk("b1_busy_t1", busy_b, 1);
    chk("b1_usb_t1", usb_rst_n_b, 0);
    measure(lo, bu, iq);
    chk("b1_low", lo, 10);
    chk("b1_busy", bu, 15);
    chk("b1_irq_during", iq, 0);
    chk("b1_irq_end", irq_b, 1);
    bus_read(2'd0, rd); chk("b1_ctrl", rd, 32'h6);
    bus_write(2'd3, 32'd0);
    chk("b1_irq_clr", irq_b, 0);
    bus_read(2'd3, rd); chk("b1_seq", rd, 1);

    // Zero lengths behave as 1/1
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h3);
    measure(lo, bu, iq);
    chk("b0_low", lo, 1);
    chk("b0_busy", bu, 2);
    chk("b0_irq", irq_b, 1);
    bus_read(2'd3, rd); chk("b0_seq", rd, 2);

    // START while busy ignored; PULSE rewrite applies to next sequence
    bus_write(2'd1, 32'd10);
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'h1);
    fork
      measure(lo, bu, iq);
      begin
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'd20);
      end
    join
    chk("b2_low", lo, 10);
    chk("b2_busy", bu, 15);
    chk("b2_irq_off", irq_b, 0);
    bus_read(2'd0, rd); chk("b2_ctrl", rd, 32'h4);
    bus_read(2'd1, rd); chk("b2_pulse_rd", rd, 20);
    bus_write(2'd0, 32'h1);
    measure(lo, bu, iq);
    chk("b3_low", lo, 20);
    chk("b3_busy", bu, 25);
    bus_read(2'd3, rd); chk("b3_seq", rd, 4);

    // 256 sequences: seq_count wraps through 255 -> 0 back to 4
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd1);
    for (int i = 0; i < 256; i++) begin
      bus_write(2'd0, 32'h1);
      measure(lo, bu, iq);
      bus_read(2'd0, rd); chk("wrap_done", rd[2], 1);
      bus_read(2'd3, rd); chk("wrap_seq", rd, (4 + i + 1) % 256);
    end

    // Reset in the middle of SETTLE
    bus_write(2'd1, 32'd10);
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'h3);
    repeat (12) @(negedge clk);
    chk("mid_in_settle", {busy_b, usb_rst_n_b}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("mid_usb_n", usb_rst_n_b, 0);
    chk("mid_busy", busy_b, 0);
    chk("mid_irq", irq_b, 0);
    bus_read(2'd0, rd); chk("mid_ctrl", rd, 0);
    bus_read(2'd1, rd); chk("mid_pulse", rd, 50000);
    bus_read(2'd2, rd); chk("mid_settle", rd, 50000);
    bus_read(2'd3, rd); chk("mid_seq", rd, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_usb_n", usb_rst_n_b, 1);
    chk("post_busy", busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
